bram_read_arbiter: RTL and testbench

BRAM_READ_ARBITER -- requirements
Module: bram_read_arbiter

---
 rtl/bram_read_arbiter.sv | 139 +++++++++++++
 tb/tb_bram_read_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_read_arbiter.sv
// Round-robin arbiter sharing one BRAM read port among NUM_PORTS requesters, with tag pipeline routing returns.
// Optional per-port saturating grant counters are built when BRAM_ARB_STATS_EN is defined.
module bram_read_arbiter #(
  parameter int NUM_PORTS       = 4,
  parameter int LOG_NUM_PORTS   = 2,
  parameter int LOG_MAX_ADDRESS = 16,
  parameter int DATA_WIDTH      = 8,
  parameter int READ_LATENCY    = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 enable,
  input  logic [NUM_PORTS-1:0]                 req_in,
  input  logic [NUM_PORTS*LOG_MAX_ADDRESS-1:0] address_in,
  output logic [NUM_PORTS-1:0]                 grant_out,
  output logic [LOG_MAX_ADDRESS-1:0]           bram_address_out,
  output logic                                 bram_request,
  input  logic                                 bram_valid_in,
  input  logic [DATA_WIDTH-1:0]                bram_data_in,
  output logic [NUM_PORTS-1:0]                 valid_out,
  output logic [DATA_WIDTH-1:0]                data_out
`ifdef BRAM_ARB_STATS_EN
  ,
  input  logic [LOG_NUM_PORTS-1:0]             stats_sel,
  output logic [15:0]                          stats_count
`endif
);

  logic [LOG_NUM_PORTS-1:0] ptr_q, ptr_d;
  logic                     grant_any;
  logic [LOG_NUM_PORTS-1:0] grant_idx;
  logic                     tag_valid_q [READ_LATENCY];
  logic [LOG_NUM_PORTS-1:0] tag_idx_q   [READ_LATENCY];
  logic                     ret_hit;

  // Two passes emulate a search starting at ptr_q and wrapping, without modulo indexing.
  always_comb begin
    grant_out        = '0;
    grant_any        = 1'b0;
    grant_idx        = '0;
    bram_address_out = '0;
    if (enable && !rst) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (!grant_any && req_in[i] && (i >= int'(ptr_q))) begin
          grant_any        = 1'b1;
          grant_idx        = LOG_NUM_PORTS'(i);
          grant_out[i]     = 1'b1;
          bram_address_out = address_in[i*LOG_MAX_ADDRESS +: LOG_MAX_ADDRESS];
        end
      end
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (!grant_any && req_in[i] && (i < int'(ptr_q))) begin
          grant_any        = 1'b1;
          grant_idx        = LOG_NUM_PORTS'(i);
          grant_out[i]     = 1'b1;
          bram_address_out = address_in[i*LOG_MAX_ADDRESS +: LOG_MAX_ADDRESS];
        end
      end
    end
  end

  assign bram_request = grant_any;

  always_comb begin
    ptr_d = ptr_q;
    if (grant_any) begin
      ptr_d = (int'(grant_idx) == NUM_PORTS - 1) ? '0 : grant_idx + LOG_NUM_PORTS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Each stage carries {valid, port}; the last stage lines up with the BRAM return.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        tag_valid_q[i] <= 1'b0;
        tag_idx_q[i]   <= '0;
      end
    end else begin
      tag_valid_q[0] <= grant_any;
      tag_idx_q[0]   <= grant_idx;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_valid_q[i] <= tag_valid_q[i-1];
        tag_idx_q[i]   <= tag_idx_q[i-1];
      end
    end
  end

  assign ret_hit  = !rst && bram_valid_in && tag_valid_q[READ_LATENCY-1];
  assign data_out = bram_data_in;

  genvar gi;
  for (gi = 0; gi < NUM_PORTS; gi++) begin : g_valid
    assign valid_out[gi] = ret_hit && (int'(tag_idx_q[READ_LATENCY-1]) == gi);
  end

`ifdef BRAM_ARB_STATS_EN
  logic [NUM_PORTS*16-1:0] cnt_flat;

  for (gi = 0; gi < NUM_PORTS; gi++) begin : g_cnt
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (grant_out[gi] && (cnt_q != 16'hFFFF)) begin
        cnt_d = cnt_q + 16'd1;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign cnt_flat[gi*16 +: 16] = cnt_q;
  end

  // Out-of-range selections read as zero.
  always_comb begin
    stats_count = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (int'(stats_sel) == i) begin
        stats_count = cnt_flat[i*16 +: 16];
      end
    end
  end
`endif

endmodule

// File: tb/tb_bram_read_arbiter.sv
// Self-checking bench for bram_read_arbiter: directed scenarios plus randomized traffic against a
// cycle-indexed reference model (round-robin pointer, scheduled BRAM returns, delivery table).
module tb_bram_read_arbiter;

  localparam int NP  = 4;
  localparam int AW  = 16;
  localparam int DW  = 8;
  localparam int LAT = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              enable;
  logic [NP-1:0]     req_in;
  logic [NP*AW-1:0]  address_in;
  logic [NP-1:0]     grant_out;
  logic [AW-1:0]     bram_address_out;
  logic              bram_request;
  logic              bram_valid_in;
  logic [DW-1:0]     bram_data_in;
  logic [NP-1:0]     valid_out;
  logic [DW-1:0]     data_out;
`ifdef BRAM_ARB_STATS_EN
  logic [1:0]        stats_sel;
  logic [15:0]       stats_count;
`endif

  bram_read_arbiter #(
    .NUM_PORTS(NP), .LOG_NUM_PORTS(2), .LOG_MAX_ADDRESS(AW),
    .DATA_WIDTH(DW), .READ_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .req_in(req_in), .address_in(address_in),
    .grant_out(grant_out), .bram_address_out(bram_address_out), .bram_request(bram_request),
    .bram_valid_in(bram_valid_in), .bram_data_in(bram_data_in),
    .valid_out(valid_out), .data_out(data_out)
`ifdef BRAM_ARB_STATS_EN
    , .stats_sel(stats_sel), .stats_count(stats_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Reference model state
  int          cyc = 0;
  int          m_ptr = 0;
  bit          bram_pend [int];
  logic [7:0]  bram_dat  [int];
  int          deliver   [int];
  logic [3:0]  exp_grant;
  logic [15:0] exp_addr;
  logic [3:0]  exp_valid;
  logic [7:0]  exp_data;

  function automatic logic [7:0] mem_data(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  // Applies one cycle of stimulus, derives expectations, advances the model, samples mid-cycle.
  task automatic drive_cycle(input logic r, input logic en, input logic [3:0] rq,
                             input logic [63:0] ad, input bit spurious);
    int g;
    @(posedge clk);
    #1;
    rst = r; enable = en; req_in = rq; address_in = ad;
    if (bram_pend.exists(cyc)) begin
      bram_valid_in = 1'b1;
      bram_data_in  = bram_dat[cyc];
    end else begin
      bram_valid_in = spurious;
      bram_data_in  = 8'($urandom);
    end
    g = -1;
    if (!r && en) begin
      for (int k = 0; k < NP; k++) begin
        int p;
        p = (m_ptr + k) % NP;
        if (g < 0 && rq[p]) g = p;
      end
    end
    exp_grant = (g >= 0) ? 4'(1 << g) : 4'b0;
    exp_addr  = (g >= 0) ? ad[g*AW +: AW] : 16'h0;
    exp_valid = '0;
    exp_data  = bram_data_in;
    if (!r && bram_valid_in && deliver.exists(cyc)) exp_valid[deliver[cyc]] = 1'b1;
    if (deliver.exists(cyc)) deliver.delete(cyc);
    if (bram_pend.exists(cyc)) begin
      bram_pend.delete(cyc);
      bram_dat.delete(cyc);
    end
    if (r) begin
      m_ptr = 0;
      deliver.delete();
    end else if (g >= 0) begin
      m_ptr = (g + 1) % NP;
      bram_pend[cyc+LAT] = 1'b1;
      bram_dat[cyc+LAT]  = mem_data(exp_addr);
      deliver[cyc+LAT]   = g;
    end
    cyc++;
    #4;
  endtask

  function automatic logic [63:0] rand_addr();
    return {$urandom, $urandom};
  endfunction

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      drive_cycle(1'b1, 1'b1, 4'hF, rand_addr(), 1'b1);
      checks++; if (grant_out !== 4'b0) $display("FAIL reset_grant k=%0d got=%b want=0000", k, grant_out); else passes++;
      checks++; if (bram_request !== 1'b0) $display("FAIL reset_req k=%0d got=%b want=0", k, bram_request); else passes++;
      checks++; if (valid_out !== 4'b0) $display("FAIL reset_valid k=%0d got=%b want=0000", k, valid_out); else passes++;
    end
    drive_cycle(1'b0, 1'b0, 4'h0, 64'h0, 1'b0);
    checks++; if (bram_address_out !== 16'h0) $display("FAIL idle_addr got=%h want=0000", bram_address_out); else passes++;
  endtask

  task automatic test_single_port();
    logic [3:0]  eg, ev;
    logic [15:0] ea;
    for (int k = 0; k < 8; k++) begin
      logic [15:0] a;
      a  = 16'h10 + 16'(k);
      drive_cycle(1'b0, 1'b1, (k < 4) ? 4'b0100 : 4'b0000, {16'h0, a, 16'h0, 16'h0}, 1'b0);
      eg = (k < 4) ? 4'b0100 : 4'b0000;
      ea = (k < 4) ? a : 16'h0;
      ev = (k >= 2 && k <= 5) ? 4'b0100 : 4'b0000;
      checks++; if (grant_out !== eg) $display("FAIL single_grant k=%0d got=%b want=%b", k, grant_out, eg); else passes++;
      checks++; if (bram_address_out !== ea) $display("FAIL single_addr k=%0d got=%h want=%h", k, bram_address_out, ea); else passes++;
      checks++; if (valid_out !== ev) $display("FAIL single_valid k=%0d got=%b want=%b", k, valid_out, ev); else passes++;
      if (ev != 0) begin
        checks++; if (data_out !== mem_data(a - 16'd2)) $display("FAIL single_data k=%0d got=%h want=%h", k, data_out, mem_data(a - 16'd2)); else passes++;
      end
    end
  endtask

  task automatic test_round_robin();
    logic [63:0] ad;
    logic [3:0]  ev;
    drive_cycle(1'b1, 1'b0, 4'h0, 64'h0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      ad = rand_addr();
      drive_cycle(1'b0, 1'b1, (k < 8) ? 4'hF : 4'h0, ad, 1'b0);
      ev = (k >= 2) ? 4'(1 << ((k - 2) % 4)) : 4'b0;
      if (k < 8) begin
        checks++; if (grant_out !== 4'(1 << (k % 4))) $display("FAIL rr_grant k=%0d got=%b want=%b", k, grant_out, 4'(1 << (k % 4))); else passes++;
        checks++; if (bram_address_out !== ad[(k%4)*AW +: AW]) $display("FAIL rr_addr k=%0d got=%h want=%h", k, bram_address_out, ad[(k%4)*AW +: AW]); else passes++;
      end
      checks++; if (valid_out !== ev) $display("FAIL rr_valid k=%0d got=%b want=%b", k, valid_out, ev); else passes++;
    end
  endtask

  task automatic test_enable_low();
    logic [3:0] gt [1:9];
    logic [3:0] vt [1:9];
    gt[1] = 4'b0010; gt[2] = 4'b1000; gt[3] = 4'b0; gt[4] = 4'b0; gt[5] = 4'b0;
    gt[6] = 4'b0010; gt[7] = 4'b1000; gt[8] = 4'b0; gt[9] = 4'b0;
    vt[1] = 4'b0; vt[2] = 4'b0; vt[3] = 4'b0010; vt[4] = 4'b1000; vt[5] = 4'b0;
    vt[6] = 4'b0; vt[7] = 4'b0; vt[8] = 4'b0010; vt[9] = 4'b1000;
    drive_cycle(1'b1, 1'b0, 4'h0, 64'h0, 1'b0);
    for (int c = 1; c <= 9; c++) begin
      drive_cycle(1'b0, !(c >= 3 && c <= 5), (c <= 7) ? 4'b1010 : 4'b0, rand_addr(), 1'b0);
      checks++; if (grant_out !== gt[c]) $display("FAIL en_grant c=%0d got=%b want=%b", c, grant_out, gt[c]); else passes++;
      checks++; if (valid_out !== vt[c]) $display("FAIL en_valid c=%0d got=%b want=%b", c, valid_out, vt[c]); else passes++;
    end
  endtask

  task automatic test_reset_midflight();
    drive_cycle(1'b1, 1'b0, 4'h0, 64'h0, 1'b0);
    drive_cycle(1'b0, 1'b1, 4'b0001, rand_addr(), 1'b0);
    checks++; if (grant_out !== 4'b0001) $display("FAIL mid_grant got=%b want=0001", grant_out); else passes++;
    drive_cycle(1'b1, 1'b1, 4'b0001, rand_addr(), 1'b0);
    checks++; if (grant_out !== 4'b0) $display("FAIL mid_rst_grant got=%b want=0000", grant_out); else passes++;
    drive_cycle(1'b0, 1'b1, 4'b0000, rand_addr(), 1'b0);
    checks++; if (valid_out !== 4'b0) $display("FAIL mid_drop got=%b want=0000 (bram_valid_in=%b)", valid_out, bram_valid_in); else passes++;
    drive_cycle(1'b0, 1'b1, 4'hF, rand_addr(), 1'b0);
    checks++; if (grant_out !== 4'b0001) $display("FAIL mid_ptr got=%b want=0001", grant_out); else passes++;
    drive_cycle(1'b0, 1'b0, 4'h0, 64'h0, 1'b0);
    drive_cycle(1'b0, 1'b0, 4'h0, 64'h0, 1'b0);
  endtask

  task automatic test_spurious();
    for (int k = 0; k < 4; k++) begin
      drive_cycle(1'b0, 1'b1, 4'h0, rand_addr(), 1'b1);
      checks++; if (valid_out !== 4'b0) $display("FAIL spurious k=%0d got=%b want=0000", k, valid_out); else passes++;
    end
  endtask

  task automatic test_random();
    logic r, en;
    for (int k = 0; k < 400; k++) begin
      r  = ($urandom_range(0, 39) == 0);
      en = ($urandom_range(0, 3) != 0);
      drive_cycle(r, en, 4'($urandom), rand_addr(), ($urandom_range(0, 3) == 0));
      checks++; if (grant_out !== exp_grant) $display("FAIL rnd_grant k=%0d got=%b want=%b", k, grant_out, exp_grant); else passes++;
      checks++; if (bram_request !== (exp_grant != 0)) $display("FAIL rnd_req k=%0d got=%b want=%b", k, bram_request, exp_grant != 0); else passes++;
      checks++; if (bram_address_out !== exp_addr) $display("FAIL rnd_addr k=%0d got=%h want=%h", k, bram_address_out, exp_addr); else passes++;
      checks++; if (valid_out !== exp_valid) $display("FAIL rnd_valid k=%0d got=%b want=%b", k, valid_out, exp_valid); else passes++;
      if (exp_valid != 0) begin
        checks++; if (data_out !== exp_data) $display("FAIL rnd_data k=%0d got=%h want=%h", k, data_out, exp_data); else passes++;
      end
    end
  endtask

`ifdef BRAM_ARB_STATS_EN
  task automatic test_stats();
    stats_sel = 2'd1;
    drive_cycle(1'b1, 1'b0, 4'h0, 64'h0, 1'b0);
    for (int k = 0; k < 100; k++) drive_cycle(1'b0, 1'b1, 4'b0010, rand_addr(), 1'b0);
    drive_cycle(1'b0, 1'b0, 4'h0, 64'h0, 1'b0);
    checks++; if (stats_count !== 16'd100) $display("FAIL stats_100 got=%h want=0064", stats_count); else passes++;
    for (int k = 0; k < 69900; k++) drive_cycle(1'b0, 1'b1, 4'b0010, 64'h0, 1'b0);
    drive_cycle(1'b0, 1'b0, 4'h0, 64'h0, 1'b0);
    checks++; if (stats_count !== 16'hFFFF) $display("FAIL stats_sat got=%h want=ffff", stats_count); else passes++;
    stats_sel = 2'd0;
    #1;
    checks++; if (stats_count !== 16'h0) $display("FAIL stats_port0 got=%h want=0000", stats_count); else passes++;
  endtask
`endif

  initial begin
    rst = 1'b1; enable = 1'b0; req_in = '0; address_in = '0;
    bram_valid_in = 1'b0; bram_data_in = '0;
`ifdef BRAM_ARB_STATS_EN
    stats_sel = '0;
`endif
    test_reset();
    test_single_port();
    test_round_robin();
    test_enable_low();
    test_reset_midflight();
    test_spurious();
    test_random();
`ifdef BRAM_ARB_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
